// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the parametrised synchronous FIFO:
//   clog2()       ceiling log2 usable in constant expressions
//   addr_w()      RAM address width for a given entry count
//   is_pow2()     power-of-two test used for the DEPTH elaboration check
//   depth_ok()    full legality check on DEPTH (power of two, >= MIN_DEPTH)
// No ports; imported by fifo_ram and fifo_sync_param.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int unsigned MIN_DEPTH = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned addr_w(input int unsigned depth);
    return clog2(depth);
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit depth_ok(input int unsigned depth);
    return is_pow2(depth) && (depth >= MIN_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// Simple dual-port storage array for the synchronous FIFO: one write port and
// one registered read port on the same clock. Array contents are never reset;
// only the read data register is cleared by the synchronous active-low reset.
// A read and a write to the same address on the same edge return the old
// contents (read-before-write), which the FIFO relies on when full.
// Ports:
//   i_clk     clock, rising edge
//   i_clr_n   synchronous active-low reset of the read register
//   i_we      write enable
//   i_waddr   write address
//   i_wdata   write data
//   i_re      read enable; o_rdata holds when low
//   i_raddr   read address
//   o_rdata   registered read data
// -----------------------------------------------------------------------------
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_clr_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned WORDS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
// Parametrised single-clock FIFO with occupancy count and programmable
// almost-full / almost-empty flags. All flags are registered from the next
// count so they change in the same cycle as count.
// Optional feature macro: FIFO_ERR_EN -- builds sticky overflow/underflow
// registers; when undefined both outputs are constant 0.
// Ports:
//   clk           rising-edge clock
//   clr           synchronous active-low reset (memory contents kept)
//   din           write data
//   wr_en         write request
//   rd_en         read request
//   dout          registered read data, 1-cycle latency, holds when idle
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         occupancy 0..DEPTH
//   overflow      sticky write-while-full (FIFO_ERR_EN only)
//   underflow     sticky read-while-empty (FIFO_ERR_EN only)
// -----------------------------------------------------------------------------
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 12,
  parameter int unsigned AE_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [DATA_W-1:0]        din,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [addr_w(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  generate
    if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("fifo_sync_param: DEPTH must be a power of two and >= 4");
    end
  endgenerate

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_almost_full;
  logic             r_almost_empty;

  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [CNT_W-1:0] w_count_nxt;

  // A full FIFO may still accept a write when a read frees the slot on the
  // same edge; an empty FIFO never serves a read (no write-to-read bypass).
  assign w_wr_ok = wr_en && (!r_full || rd_en);
  assign w_rd_ok = rd_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count        <= w_count_nxt;
      r_full         <= (32'(w_count_nxt) == DEPTH);
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (32'(w_count_nxt) >= AF_THRESH);
      r_almost_empty <= (32'(w_count_nxt) <= AE_THRESH);
    end
  end

  // Pointers carry one extra wrap bit; only the low ADDR_W bits address RAM.
  fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (clk),
    .i_clr_n (clr),
    .i_we    (w_wr_ok),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (din),
    .i_re    (w_rd_ok),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (dout)
  );

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;

`ifdef FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && r_full && !rd_en) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
